// File: rtl/risc16_pkg.sv
// Shared definitions for the risc16 memory-side blocks: RAM port encodings,
// loader FSM state codes, widths and the default frame start marker.
package risc16_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;

   // rw strobe encodings on the unified RAM port
   localparam logic READ  = 1'b0;
   localparam logic WRITE = 1'b1;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // loader FSM state codes
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_LEN_HI  = 4'd1;
   localparam logic [3:0] S_LEN_LO  = 4'd2;
   localparam logic [3:0] S_DATA_HI = 4'd3;
   localparam logic [3:0] S_DATA_LO = 4'd4;
   localparam logic [3:0] S_CHK     = 4'd5;
   localparam logic [3:0] S_VERIFY  = 4'd6;
   localparam logic [3:0] S_DONE    = 4'd7;
   localparam logic [3:0] S_ERR     = 4'd8;

endpackage

// File: rtl/loader_cksum.sv
// 8-bit mod-256 accumulator with clear, add-byte and add-word inputs.
// match compares the post-update sum against ref_val, so a caller can decide
// on the same edge that folds in the final byte or word.
module loader_cksum
   import risc16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              add_byte,
   input  logic [7:0]        byte_in,
   input  logic              add_word,
   input  logic [WORD_W-1:0] word_in,
   input  logic [7:0]        ref_val,
   output logic              match
);

   logic [7:0] sum;
   logic [7:0] sum_nxt;

   // next sum: clear wins over any add in the same cycle
   always_comb begin
      sum_nxt = sum;
      if (add_byte) sum_nxt = sum_nxt + byte_in;
      if (add_word) sum_nxt = sum_nxt + word_in[WORD_W-1:8] + word_in[7:0];
      if (clr)      sum_nxt = 8'h00;
   end

   assign match = (sum_nxt == ref_val);

   // accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum <= 8'h00;
      else        sum <= sum_nxt;
   end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/data/CHK frames from the host
// link, writes the image into the unified RAM while holding the CPU, then
// reads it back and releases the CPU only if both checksums agree.
module prog_loader
   import risc16_pkg::*;
#(
   parameter int         MEM_SIZE  = 2048,
   parameter int         BASE_ADDR = 0,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] addr,
   output logic              rw,
   output logic [WORD_W-1:0] mem_in,
   input  logic [WORD_W-1:0] mem_out,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // longest image that fits between BASE_ADDR and the top of RAM
   localparam logic [16:0]       LEN_MAX = 17'(MEM_SIZE - BASE_ADDR);
   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

   logic [3:0]  state;
   logic [15:0] len;
   logic [15:0] idx;
   logic [7:0]  hi_byte;
   logic [7:0]  expected;

   logic        acc;
   logic        idle_like;
   logic        is_sync;
   logic [15:0] len_new;
   logic [7:0]  chk_ref;
   logic        rx_ok;
   logic        rd_ok;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
   assign rx_ready  = (state != S_VERIFY);
   assign busy      = !idle_like;
   assign acc       = rx_valid & rx_ready;
   assign is_sync   = (rx_data == SYNC_BYTE);
   assign len_new   = {len[15:8], rx_data};

   // In CHK the expected value is still on rx_data; afterwards it is latched.
   assign chk_ref = (state == S_CHK) ? rx_data : expected;

   // receive sum over all data bytes, restarted by each SYNC
   loader_cksum u_rx_sum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc && idle_like && is_sync),
      .add_byte (acc && ((state == S_DATA_HI) || (state == S_DATA_LO))),
      .byte_in  (rx_data),
      .add_word (1'b0),
      .word_in  ('0),
      .ref_val  (chk_ref),
      .match    (rx_ok)
   );

   // readback sum over RAM words, restarted when CHK is accepted
   loader_cksum u_rd_sum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (acc && (state == S_CHK)),
      .add_byte (1'b0),
      .byte_in  (8'h00),
      .add_word (state == S_VERIFY),
      .word_in  (mem_out),
      .ref_val  (chk_ref),
      .match    (rd_ok)
   );

   // frame FSM, index counter and registered RAM port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         len      <= '0;
         idx      <= '0;
         hi_byte  <= '0;
         expected <= '0;
         addr     <= '0;
         rw       <= READ;
         mem_in   <= '0;
         cpu_hold <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
      end else begin
         // the write strobe is a single-cycle pulse unless re-armed below
         rw <= READ;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (acc && is_sync) begin
                  state    <= S_LEN_HI;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  cpu_hold <= 1'b1;
                  idx      <= '0;
               end
            end
            S_LEN_HI: begin
               if (acc) begin
                  len[15:8] <= rx_data;
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (acc) begin
                  len[7:0] <= rx_data;
                  if ({1'b0, len_new} > LEN_MAX) begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end else if (len_new == 16'd0) begin
                     state <= S_CHK;
                  end else begin
                     state <= S_DATA_HI;
                  end
               end
            end
            S_DATA_HI: begin
               if (acc) begin
                  hi_byte <= rx_data;
                  state   <= S_DATA_LO;
               end
            end
            S_DATA_LO: begin
               if (acc) begin
                  rw     <= WRITE;
                  addr   <= BASE + idx;
                  mem_in <= {hi_byte, rx_data};
                  idx    <= idx + 16'd1;
                  state  <= (idx + 16'd1 == len) ? S_CHK : S_DATA_HI;
               end
            end
            S_CHK: begin
               if (acc) begin
                  expected <= rx_data;
                  idx      <= '0;
                  addr     <= BASE;
                  if (len != 16'd0) begin
                     state <= S_VERIFY;
                  end else if (rx_ok && rd_ok) begin
                     // empty image: nothing to read back, compare now
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
            S_VERIFY: begin
               addr <= addr + 16'd1;
               idx  <= idx + 16'd1;
               if (idx == len - 16'd1) begin
                  if (rx_ok && rd_ok) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     // keep the CPU held so a corrupt image never runs
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a table of whole frames with hand-computed
// write traces and final flags, plus a reset-in-mid-frame sequence.
module tb_prog_loader;
   import risc16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [15:0] addr;
   logic        rw;
   logic [15:0] mem_in;
   logic [15:0] mem_out;
   logic        cpu_hold, busy, done, error;

   logic [15:0] ram [0:2047];
   bit          corrupt = 1'b0;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   prog_loader #(.MEM_SIZE(2048), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .addr     (addr),
      .rw       (rw),
      .mem_in   (mem_in),
      .mem_out  (mem_out),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   // RAM model: combinational read, posedge write; corrupt flips bit 0 on store
   assign mem_out = ram[addr[10:0]];
   always @(posedge clk)
      if (rw) ram[addr[10:0]] <= corrupt ? (mem_in ^ 16'h0001) : mem_in;

   // observe the RAM port mid-cycle
   logic [15:0] wa[$];
   logic [15:0] wd[$];
   int vcyc = 0;
   int rw_in_verify = 0;
   always @(negedge clk) begin
      if (rw === 1'b1) begin
         wa.push_back(addr);
         wd.push_back(mem_in);
      end
      if (rx_ready === 1'b0) vcyc++;
      if (rw === 1'b1 && rx_ready === 1'b0) rw_in_verify++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // offer one byte from posedge+1; accepted on the following posedge
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      while (rx_ready !== 1'b1 && t < 64) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 64) chk("rx_ready_timeout", 32'd0, 32'd1);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_addr"},     32'(addr),     32'h0);
      chk({tag, "_rw"},       32'(rw),       32'h0);
      chk({tag, "_mem_in"},   32'(mem_in),   32'h0);
      chk({tag, "_rx_ready"}, 32'(rx_ready), 32'h1);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'h0);
      chk({tag, "_busy"},     32'(busy),     32'h0);
      chk({tag, "_done"},     32'(done),     32'h0);
      chk({tag, "_error"},    32'(error),    32'h0);
   endtask

   typedef struct {
      string       name;
      int          nb;
      logic [7:0]  b [12];
      bit          gap;
      bit          corrupt;
      int          exp_nw;
      logic [15:0] exp_a [2];
      logic [15:0] exp_d [2];
      int          exp_vcyc;
      bit          exp_done;
      bit          exp_err;
      bit          exp_hold;
   } vec_t;

   vec_t v [6];

   initial begin
      int w0, vc0, rv0, t;

      // data bytes 12+34+AB+CD = 1BE -> CHK BE; 12+34 = 46
      v[0] = '{"good2", 8,
               '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b0, 2, '{16'h0000, 16'h0001}, '{16'h1234, 16'hABCD}, 2, 1'b1, 1'b0, 1'b0};
      v[1] = '{"badchk", 8,
               '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b0, 2, '{16'h0000, 16'h0001}, '{16'h1234, 16'hABCD}, 2, 1'b0, 1'b1, 1'b1};
      v[2] = '{"junk_len0", 6,
               '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b0, 0, '{16'h0000, 16'h0000}, '{16'h0000, 16'h0000}, 0, 1'b1, 1'b0, 1'b0};
      v[3] = '{"len_over", 3,
               '{8'hA5, 8'h08, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b0, 0, '{16'h0000, 16'h0000}, '{16'h0000, 16'h0000}, 0, 1'b0, 1'b1, 1'b1};
      v[4] = '{"gapped1", 6,
               '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b1, 1'b0, 1, '{16'h0000, 16'h0000}, '{16'h1234, 16'h0000}, 1, 1'b1, 1'b0, 1'b0};
      // RAM stores 1235, readback sum 47 != 46
      v[5] = '{"ram_corrupt", 6,
               '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h46, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               1'b0, 1'b1, 1, '{16'h0000, 16'h0000}, '{16'h1234, 16'h0000}, 1, 1'b0, 1'b1, 1'b1};

      for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;

      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset asserted while in LEN_LO takes effect without a clock edge
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("mid_busy_before",     32'(busy),     32'h1);
      chk("mid_cpu_hold_before", 32'(cpu_hold), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // frame table
      for (int i = 0; i < 6; i++) begin
         w0      = wa.size();
         vc0     = vcyc;
         rv0     = rw_in_verify;
         corrupt = v[i].corrupt;
         for (int k = 0; k < v[i].nb; k++) send_byte(v[i].b[k], v[i].gap);
         t = 0;
         while (busy !== 1'b0 && t < 200) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 200) chk({v[i].name, "_busy_timeout"}, 32'd0, 32'd1);
         chk({v[i].name, "_done"},     32'(done),     32'(v[i].exp_done));
         chk({v[i].name, "_error"},    32'(error),    32'(v[i].exp_err));
         chk({v[i].name, "_cpu_hold"}, 32'(cpu_hold), 32'(v[i].exp_hold));
         chk({v[i].name, "_rx_ready"}, 32'(rx_ready), 32'h1);
         chk({v[i].name, "_rw_idle"},  32'(rw),       32'h0);
         chk({v[i].name, "_nwrites"},  32'(wa.size() - w0), 32'(v[i].exp_nw));
         for (int j = 0; j < v[i].exp_nw; j++) begin
            if (w0 + j < wa.size()) begin
               chk({v[i].name, "_waddr"}, 32'(wa[w0 + j]), 32'(v[i].exp_a[j]));
               chk({v[i].name, "_wdata"}, 32'(wd[w0 + j]), 32'(v[i].exp_d[j]));
            end
         end
         chk({v[i].name, "_verify_cycles"}, 32'(vcyc - vc0), 32'(v[i].exp_vcyc));
         chk({v[i].name, "_rw_in_verify"},  32'(rw_in_verify - rv0), 32'h0);
         repeat (2) @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
